// File: rtl/mat_bram_loader_if.sv
// Host-stream and BRAM write-port bundle for mat_bram_loader.
// The master side is the host/DMA; the slave side is the loader.
interface mat_bram_loader_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  start;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  in_mat_ena;
  logic                  in_mat_wea;
  logic [ADDR_WIDTH-1:0] in_mat_wr_addra;
  logic [DATA_WIDTH-1:0] in_mat_dina;
  logic                  in_mat_enb;
  logic                  in_mat_web;
  logic [ADDR_WIDTH-1:0] in_mat_wr_addrb;
  logic [DATA_WIDTH-1:0] in_mat_dinb;
  logic                  busy;
  logic                  load_done;
  logic                  err_len;

  modport master (
    output start, s_valid, s_data, s_last,
    input  s_ready,
    input  in_mat_ena, in_mat_wea, in_mat_wr_addra, in_mat_dina,
    input  in_mat_enb, in_mat_web, in_mat_wr_addrb, in_mat_dinb,
    input  busy, load_done, err_len
  );

  modport slave (
    input  start, s_valid, s_data, s_last,
    output s_ready,
    output in_mat_ena, in_mat_wea, in_mat_wr_addra, in_mat_dina,
    output in_mat_enb, in_mat_web, in_mat_wr_addrb, in_mat_dinb,
    output busy, load_done, err_len
  );
endinterface

// File: rtl/mat_bram_loader.sv
// Streams TOTAL_WORDS words into the attention input BRAM as paired A/B writes.
// Optional stream-length check on s_last: define LOADER_LAST_CHECK_EN.
module mat_bram_loader #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned TOTAL_WORDS = 512
) (
  input logic               clk,
  input logic               rst,
  mat_bram_loader_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(TOTAL_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] EVEN_MASK = ADDR_WIDTH'(~32'd1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  ena_q, ena_d;
  logic                  enb_q, enb_d;
  logic [ADDR_WIDTH-1:0] addra_q, addra_d;
  logic [ADDR_WIDTH-1:0] addrb_q, addrb_d;
  logic [DATA_WIDTH-1:0] dina_q, dina_d;
  logic [DATA_WIDTH-1:0] dinb_q, dinb_d;
  logic                  busy_q, busy_d;
  logic                  load_done_q, load_done_d;
`ifdef LOADER_LAST_CHECK_EN
  logic                  err_len_q, err_len_d;
`endif

  logic accept_c;
  logic final_c;

  assign accept_c = bus.s_valid && (state_q == S_LOAD);
  assign final_c  = (cnt_q == LAST_IDX);

  // Next-state, pairing and write-port logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    ena_d       = 1'b0;
    enb_d       = 1'b0;
    addra_d     = addra_q;
    addrb_d     = addrb_q;
    dina_d      = dina_q;
    dinb_d      = dinb_q;
    load_done_d = 1'b0;
`ifdef LOADER_LAST_CHECK_EN
    err_len_d   = err_len_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
`ifdef LOADER_LAST_CHECK_EN
          err_len_d = 1'b0;
`endif
        end
      end

      S_LOAD: begin
        if (accept_c) begin
          cnt_d = cnt_q + 1'b1;
          if (!cnt_q[0]) begin
            // Even word waits for its odd partner unless it closes an odd-length load
            if (final_c) begin
              ena_d   = 1'b1;
              addra_d = cnt_q;
              dina_d  = bus.s_data;
            end else begin
              hold_d  = bus.s_data;
            end
          end else begin
            ena_d   = 1'b1;
            enb_d   = 1'b1;
            addra_d = cnt_q & EVEN_MASK;
            dina_d  = hold_q;
            addrb_d = cnt_q;
            dinb_d  = bus.s_data;
          end
`ifdef LOADER_LAST_CHECK_EN
          if (bus.s_last != final_c) begin
            err_len_d = 1'b1;
          end
`endif
          if (final_c) begin
            state_d = S_FLUSH;
          end
        end
      end

      S_FLUSH: begin
        state_d     = S_DONE;
        load_done_d = 1'b1;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      ena_q       <= 1'b0;
      enb_q       <= 1'b0;
      addra_q     <= '0;
      addrb_q     <= '0;
      dina_q      <= '0;
      dinb_q      <= '0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
`ifdef LOADER_LAST_CHECK_EN
      err_len_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      ena_q       <= ena_d;
      enb_q       <= enb_d;
      addra_q     <= addra_d;
      addrb_q     <= addrb_d;
      dina_q      <= dina_d;
      dinb_q      <= dinb_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
`ifdef LOADER_LAST_CHECK_EN
      err_len_q   <= err_len_d;
`endif
    end
  end

  // s_ready is a pure decode of the state so it tracks LOAD with no extra cycle
  assign bus.s_ready         = (state_q == S_LOAD);
  assign bus.busy            = busy_q;
  assign bus.load_done       = load_done_q;
  assign bus.in_mat_ena      = ena_q;
  assign bus.in_mat_wea      = ena_q;
  assign bus.in_mat_enb      = enb_q;
  assign bus.in_mat_web      = enb_q;
  assign bus.in_mat_wr_addra = addra_q;
  assign bus.in_mat_wr_addrb = addrb_q;
  assign bus.in_mat_dina     = dina_q;
  assign bus.in_mat_dinb     = dinb_q;

`ifdef LOADER_LAST_CHECK_EN
  assign bus.err_len = err_len_q;
`else
  logic unused_s_last;
  assign unused_s_last = bus.s_last;
  assign bus.err_len   = 1'b0;
`endif

endmodule

// File: tb/tb_mat_bram_loader.sv
// Scoreboard bench for mat_bram_loader: a 4-word instance and a 3-word instance.
module tb_mat_bram_loader;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 10;
`ifdef LOADER_LAST_CHECK_EN
  localparam bit LC = 1'b1;
`else
  localparam bit LC = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] aa;
    logic [DW-1:0] da;
    logic          b_en;
    logic [AW-1:0] ab;
    logic [DW-1:0] db;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_s [2];
  logic          valid_s [2];
  logic          last_s  [2];
  logic [DW-1:0] data_s  [2];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  wr_t exp_q0[$];
  wr_t exp_q1[$];
  int  done_q0[$];
  int  done_q1[$];

  mat_bram_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
  mat_bram_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

  assign bus0.start   = start_s[0];
  assign bus0.s_valid = valid_s[0];
  assign bus0.s_last  = last_s[0];
  assign bus0.s_data  = data_s[0];
  assign bus1.start   = start_s[1];
  assign bus1.s_valid = valid_s[1];
  assign bus1.s_last  = last_s[1];
  assign bus1.s_data  = data_s[1];

  mat_bram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TOTAL_WORDS(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );
  mat_bram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TOTAL_WORDS(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic wr_t mkw(input int aa, input logic [DW-1:0] da, input bit b,
                              input int ab, input logic [DW-1:0] db);
    wr_t w;
    w.aa = AW'(aa); w.da = da; w.b_en = b; w.ab = AW'(ab); w.db = db;
    return w;
  endfunction

  task automatic push_w(input int i, input wr_t w);
    if (i == 0) exp_q0.push_back(w);
    else        exp_q1.push_back(w);
  endtask

  // Expected writes for a full 4-word load starting at data value base
  task automatic push_four(input logic [DW-1:0] base);
    push_w(0, mkw(0, base,         1'b1, 1, base + 64'd1));
    push_w(0, mkw(2, base + 64'd2, 1'b1, 3, base + 64'd3));
  endtask

  function automatic logic rdy(input int i);
    return (i == 0) ? bus0.s_ready : bus1.s_ready;
  endfunction
  function automatic logic bsy(input int i);
    return (i == 0) ? bus0.busy : bus1.busy;
  endfunction
  function automatic logic erl(input int i);
    return (i == 0) ? bus0.err_len : bus1.err_len;
  endfunction

  // Monitor: pop expected write / done event whenever the DUT presents one
  task automatic mon(input int i, input logic ena, input logic wea, input logic enb,
                     input logic web, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                     input logic [AW-1:0] ab, input logic [DW-1:0] db, input logic done);
    wr_t e;
    int  dc;
    bit  have;
    if (ena || wea || enb || web) begin
      have = (i == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
      if (!have) begin
        chk($sformatf("dut%0d_spurious_wr", i), 64'd1, 64'd0);
      end else begin
        if (i == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        chk($sformatf("dut%0d_ena", i), 64'(ena), 64'd1);
        chk($sformatf("dut%0d_wea", i), 64'(wea), 64'd1);
        chk($sformatf("dut%0d_addra", i), 64'(aa), 64'(e.aa));
        chk($sformatf("dut%0d_dina", i), da, e.da);
        chk($sformatf("dut%0d_enb", i), 64'(enb), 64'(e.b_en));
        chk($sformatf("dut%0d_web", i), 64'(web), 64'(e.b_en));
        if (e.b_en) begin
          chk($sformatf("dut%0d_addrb", i), 64'(ab), 64'(e.ab));
          chk($sformatf("dut%0d_dinb", i), db, e.db);
        end
      end
    end
    if (done) begin
      have = (i == 0) ? (done_q0.size() > 0) : (done_q1.size() > 0);
      if (!have) begin
        chk($sformatf("dut%0d_spurious_done", i), 64'd1, 64'd0);
      end else begin
        if (i == 0) dc = done_q0.pop_front();
        else        dc = done_q1.pop_front();
        chk($sformatf("dut%0d_done_cycle", i), 64'(cyc), 64'(dc));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus0.in_mat_ena, bus0.in_mat_wea, bus0.in_mat_enb, bus0.in_mat_web,
        bus0.in_mat_wr_addra, bus0.in_mat_dina, bus0.in_mat_wr_addrb, bus0.in_mat_dinb,
        bus0.load_done);
    mon(1, bus1.in_mat_ena, bus1.in_mat_wea, bus1.in_mat_enb, bus1.in_mat_web,
        bus1.in_mat_wr_addra, bus1.in_mat_dina, bus1.in_mat_wr_addrb, bus1.in_mat_dinb,
        bus1.load_done);
  end

  // All drive tasks start and end at posedge+1
  task automatic step(input int i, input bit v, input logic [DW-1:0] d, input bit lst,
                      input bit err_exp, output int c);
    valid_s[i] = v;
    data_s[i]  = d;
    last_s[i]  = lst;
    c = cyc;
    @(negedge clk);
    if (v) chk($sformatf("dut%0d_s_ready", i), 64'(rdy(i)), 64'd1);
    chk($sformatf("dut%0d_busy", i), 64'(bsy(i)), 64'd1);
    chk($sformatf("dut%0d_err_len", i), 64'(erl(i)), 64'(err_exp));
    @(posedge clk);
    #1;
    valid_s[i] = 1'b0;
    last_s[i]  = 1'b0;
  endtask

  task automatic pulse(input int i);
    start_s[i] = 1'b1;
    @(negedge clk);
    chk($sformatf("dut%0d_ready_idle", i), 64'(rdy(i)), 64'd0);
    @(posedge clk);
    #1;
    start_s[i] = 1'b0;
  endtask

  // Feed n words; vpat gives s_valid for the first plen cycles, sj pulses start, bad_k flips s_last
  task automatic load(input int i, input logic [DW-1:0] base, input int n,
                      input logic [31:0] vpat, input int plen, input int bad_k, input int sj);
    int k = 0;
    int c;
    bit v;
    bit lst;
    bit err_exp = 1'b0;
    for (int j = 0; j < 64 && k < n; j++) begin
      v   = (j < plen) ? vpat[j] : 1'b1;
      lst = v && ((k == n - 1) != (k == bad_k));
      start_s[i] = (j == sj);
      step(i, v, base + 64'(k), lst, err_exp, c);
      if (v) begin
        if (k == bad_k) err_exp = LC;
        if (k == n - 1) begin
          if (i == 0) done_q0.push_back(c + 2);
          else        done_q1.push_back(c + 2);
        end
        k++;
      end
    end
    start_s[i] = 1'b0;
    if (k < n) chk($sformatf("dut%0d_load_words", i), 64'(k), 64'(n));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int i);
    idle(4);
    @(negedge clk);
    chk($sformatf("dut%0d_busy_after", i), 64'(bsy(i)), 64'd0);
    chk($sformatf("dut%0d_ready_after", i), 64'(rdy(i)), 64'd0);
    @(posedge clk);
    #1;
    chk("wr_q0_left", 64'(exp_q0.size()), 64'd0);
    chk("wr_q1_left", 64'(exp_q1.size()), 64'd0);
    chk("done_q0_left", 64'(done_q0.size()), 64'd0);
    chk("done_q1_left", 64'(done_q1.size()), 64'd0);
  endtask

  initial begin
    int c;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      valid_s[i] = 1'b0;
      last_s[i]  = 1'b0;
      data_s[i]  = '0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready",   64'(bus0.s_ready), 64'd0);
    chk("rst_busy",      64'(bus0.busy), 64'd0);
    chk("rst_load_done", 64'(bus0.load_done), 64'd0);
    chk("rst_err_len",   64'(bus0.err_len), 64'd0);
    chk("rst_ena",       64'(bus0.in_mat_ena), 64'd0);
    chk("rst_enb",       64'(bus0.in_mat_enb), 64'd0);
    chk("rst_addra",     64'(bus0.in_mat_wr_addra), 64'd0);
    chk("rst_addrb",     64'(bus0.in_mat_wr_addrb), 64'd0);
    chk("rst_dina",      bus0.in_mat_dina, 64'd0);
    chk("rst_dinb",      bus0.in_mat_dinb, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Even length, back-to-back
    push_four(64'hA0);
    pulse(0);
    load(0, 64'hA0, 4, 32'd0, 0, -1, -1);
    drain(0);

    // Odd length: paired write then port-A-only write
    push_w(1, mkw(0, 64'hB0, 1'b1, 1, 64'hB1));
    push_w(1, mkw(2, 64'hB2, 1'b0, 0, 64'h0));
    pulse(1);
    load(1, 64'hB0, 3, 32'd0, 0, -1, -1);
    drain(1);

    // Stalled stream: s_valid 1,0,0,1,1,0,1
    push_four(64'hC0);
    pulse(0);
    load(0, 64'hC0, 4, 32'b1011001, 7, -1, -1);
    drain(0);

    // start pulsed in a gap after two words must be ignored
    push_four(64'hD0);
    pulse(0);
    load(0, 64'hD0, 4, 32'b011, 3, -1, 2);
    drain(0);

    // Reset after one accepted word: nothing written, outputs cleared
    pulse(0);
    step(0, 1'b1, 64'hEE, 1'b0, 1'b0, c);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ena",   64'(bus0.in_mat_ena), 64'd0);
    chk("midrst_enb",   64'(bus0.in_mat_enb), 64'd0);
    chk("midrst_ready", 64'(bus0.s_ready), 64'd0);
    chk("midrst_busy",  64'(bus0.busy), 64'd0);
    chk("midrst_addra", 64'(bus0.in_mat_wr_addra), 64'd0);
    chk("midrst_dina",  bus0.in_mat_dina, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    push_four(64'hE0);
    pulse(0);
    load(0, 64'hE0, 4, 32'd0, 0, -1, -1);
    drain(0);

    // Wrong s_last on word 1: flag only when the check is compiled in
    push_four(64'hF0);
    pulse(0);
    load(0, 64'hF0, 4, 32'd0, 0, 1, -1);
    drain(0);
    @(negedge clk);
    chk("err_len_sticky", 64'(bus0.err_len), 64'(LC));
    @(posedge clk);
    #1;
    push_four(64'h10);
    pulse(0);
    load(0, 64'h10, 4, 32'd0, 0, -1, -1);
    drain(0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
